multi_issue: RTL
================

# multi_issue

Request front end for the fixed-latency 64-bit multi-cycle unit. Accepts operands on a valid/ready stream and pulses `start` with the operand held on `inp`. It captures the unit's `out` exactly `LATENCY` cycles later and returns results in order on a valid/ready response stream through a small buffer. Its `start`/`inp` outputs connect directly to the unit, which has no `done` output, and its `unit_out` input connects to the unit's `out`.

## Interface
- `LATENCY`, 3: cycles from the `start` cycle to the cycle `out` is valid. Must be ≥1.
- `DEPTH`, 2: response buffer entries. Must be ≥1.
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request operand valid.
- `req_ready` out 1: block can accept a request.
- `req_data` in 64: operand.
- `start` out 1: one-cycle start pulse to the unit.
- `inp` out 64: operand to the unit; held stable from `start` until capture.
- `unit_out` in 64: unit result.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts the result.
- `resp_data` out 64: result, oldest first.

## Operation
- FSM states: IDLE, START, WAIT.
- **IDLE**
  - `req_ready` = 1 iff the buffer is not full.
  - On `req_valid & req_ready`: latch `req_data` into `inp_q` and go to START.
- **START**
  - `start` = 1 for this cycle only.
  - Clear the counter and go to WAIT.
- **WAIT**
  - Increment the counter each cycle.
  - When counter == `LATENCY`-1, i.e. the cycle where `unit_out` is valid: push `unit_out` into the buffer and go to IDLE.
- Space is reserved at acceptance, so a push never finds the buffer full. `req_ready` = 0 in START and WAIT.
- At most one operation is in flight. No request is accepted while one is pending.
- `inp` = `inp_q` at all times. `inp_q` changes only on an accepted request.
- Buffer is FIFO:
  - `resp_valid` = not empty; `resp_data` = head entry.
  - Pop on `resp_valid & resp_ready`.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- `resp_data` must not change while `resp_valid & !resp_ready`.
- Reset values: state IDLE, `start` 0, `inp` 0, counter 0, buffer empty, `resp_valid` 0.
  - `req_ready` is 1 in the first cycle after reset.
- Reset mid-operation: the in-flight operation is abandoned (no push) and buffered results are discarded. A late `unit_out` is ignored.

## Timing
- Request handshake in cycle T; `start` high in T+1.
- `unit_out` sampled at the end of T+1+`LATENCY`.
- `resp_valid` high in T+2+`LATENCY` if the buffer was empty. Same cycle, `req_ready` returns high if the buffer is not full.
- Back-to-back throughput, consumer always ready: one request per `LATENCY`+2 cycles.
- With `resp_ready` held low: exactly `DEPTH` requests are accepted, then `req_ready` stays 0 until a pop.
- Combinational paths: `req_ready` depends on state and buffer occupancy only. `req_ready` has no path from `req_valid`. No path from `resp_ready` to `resp_valid` or `resp_data`.

## Structure
- Package `multi_pkg` holds:
  - `DATA_W` = 64.
  - The FSM state enum (IDLE/START/WAIT).
  - The default `LATENCY`.
- Sub-module `multi_resp_fifo`: synchronous FIFO, parameters `DATA_W` and `DEPTH`, ports push/pop/full/empty/head. Pointers wrap modulo `DEPTH`, with an occupancy count of width $clog2(`DEPTH`+1).
- Counter width is $clog2(`LATENCY`+1).
- Bench model for `unit_out`: delays `inp` by `LATENCY` cycles and returns `inp` + `0x0000_0001_0000_0001`, holding the value in later cycles.

## Test plan
- **Single op:** request 0x0000_0005_0000_0007 at T.
  - `start` high only at T+1.
  - `resp_valid` at T+5 with `resp_data` 0x0000_0006_0000_0008.
- **Back-to-back:** `req_valid` held high with 0x10, 0x20, 0x30 and `resp_ready`=1.
  - Accepts spaced 5 cycles apart.
  - Responses 0x0000_0001_0000_0011, …_0021, …_0031 in order.
- **Back-pressure:** `resp_ready`=0 and 3 requests offered.
  - 2 accepted, then `req_ready` stays 0 and `resp_data` stays stable.
  - Raise `resp_ready`: the third request is accepted in the cycle after the first pop.
- **Simultaneous push/pop:** buffer holds 1 entry and a capture coincides with a pop.
  - Occupancy stays 1 and order is preserved.
- **Reset mid-WAIT:** assert `reset` 2 cycles after `start`.
  - After reset, `resp_valid` stays 0 for 10 cycles and `req_ready`=1.
  - A new request completes normally.
- **Operand stability:** toggle `req_data` randomly during WAIT.
  - `inp` stays equal to the accepted operand until the next accepted request.

Source files
------------

// File: rtl/multi_pkg.sv
// Shared constants and FSM encoding for the multi-cycle unit request front end.
package multi_pkg;
    localparam int DATA_W      = 64;
    localparam int LATENCY_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;
endpackage

// File: rtl/multi_resp_fifo.sv
// Small in-order response buffer; head is presented combinationally from storage.
module multi_resp_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && !full;

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/multi_issue.sv
// Issues one operation at a time to a fixed-latency unit and returns its results
// in order through a small response buffer.
module multi_issue
    import multi_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int DEPTH   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    output logic              start,
    output logic [DATA_W-1:0] inp,
    input  logic [DATA_W-1:0] unit_out,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data
);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    state_t            r_state;
    logic              r_start;
    logic [DATA_W-1:0] r_inp_q;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_req_ready;

    // Only accepting from IDLE with a free slot reserves the slot the capture will use.
    assign w_req_ready = (r_state == IDLE) && !w_full;
    assign w_push      = (r_state == WAIT) && (r_cnt == LAST_CNT);

    assign req_ready  = w_req_ready;
    assign start      = r_start;
    assign inp        = r_inp_q;
    assign resp_valid = !w_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_start <= 1'b0;
            r_inp_q <= '0;
            r_cnt   <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && w_req_ready) begin
                        r_inp_q <= req_data;
                        r_start <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    multi_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (unit_out),
        .pop       (resp_ready),
        .full      (w_full),
        .empty     (w_empty),
        .head      (resp_data)
    );
endmodule
